// File: rtl/mul_arb_pkg.sv
// Shared constants and requester ID encoding for the two-requester multiplier arbiter.
package mul_arb_pkg;
  localparam int DEF_W = 4;
  localparam int RES_W = 2 * DEF_W;
  localparam int LAT   = 2;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;
endpackage

// File: rtl/mul_core_2stage.sv
// Two-stage unsigned WxW multiplier: operand capture, then product register;
// valid and requester ID ride alongside the data.
module mul_core_2stage
  import mul_arb_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           in_vld,
  input  req_id_e        in_id,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           out_vld,
  output req_id_e        out_id,
  output logic [2*W-1:0] out_prod
);
  localparam int RW = 2 * W;

  logic         s1_vld;
  req_id_e      s1_id;
  logic [W-1:0] s1_a;
  logic [W-1:0] s1_b;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1_vld <= 1'b0;
      s1_id  <= REQ0;
      s1_a   <= '0;
      s1_b   <= '0;
    end else begin
      s1_vld <= in_vld;
      if (in_vld) begin
        s1_id <= in_id;
        s1_a  <= in_a;
        s1_b  <= in_b;
      end
    end
  end

  // Operands widened to the full result width so nothing is truncated.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      out_vld  <= 1'b0;
      out_id   <= REQ0;
      out_prod <= '0;
    end else begin
      out_vld <= s1_vld;
      if (s1_vld) begin
        out_id   <= s1_id;
        out_prod <= RW'({{W{1'b0}}, s1_a} * {{W{1'b0}}, s1_b});
      end
    end
  end
endmodule

// File: rtl/mul_share_arbiter.sv
// Two requesters sharing one pipelined multiplier; round-robin grant by default,
// fixed priority to requester 0 when MUL_ARB_FIXED_PRIO_EN is defined.
module mul_share_arbiter
  import mul_arb_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           req0,
  input  logic [W-1:0]   a0,
  input  logic [W-1:0]   b0,
  output logic           gnt0,
  input  logic           req1,
  input  logic [W-1:0]   a1,
  input  logic [W-1:0]   b1,
  output logic           gnt1,
  output logic [2*W-1:0] res,
  output logic           rvld0,
  output logic           rvld1,
  output logic [1:0]     inflight
);
  logic           xfer;
  req_id_e        iss_id;
  logic [W-1:0]   iss_a;
  logic [W-1:0]   iss_b;
  logic           core_vld;
  req_id_e        core_id;
  logic [2*W-1:0] core_prod;

`ifdef MUL_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!clr) begin
      gnt0 = req0;
      gnt1 = req1 & ~req0;
    end
  end
`else
  // ptr names the requester that wins the next tie.
  req_id_e ptr;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!clr) begin
      if (req0 && req1) begin
        gnt0 = (ptr == REQ0);
        gnt1 = (ptr == REQ1);
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ptr <= REQ0;
    end else if (gnt0) begin
      ptr <= REQ1;
    end else if (gnt1) begin
      ptr <= REQ0;
    end
  end
`endif

  assign xfer   = gnt0 | gnt1;
  assign iss_id = gnt1 ? REQ1 : REQ0;
  assign iss_a  = gnt1 ? a1 : a0;
  assign iss_b  = gnt1 ? b1 : b0;

  mul_core_2stage #(.W(W)) u_core (
    .clk      (clk),
    .clr      (clr),
    .in_vld   (xfer),
    .in_id    (iss_id),
    .in_a     (iss_a),
    .in_b     (iss_b),
    .out_vld  (core_vld),
    .out_id   (core_id),
    .out_prod (core_prod)
  );

  // res holds its previous value between returned products.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      res   <= '0;
      rvld0 <= 1'b0;
      rvld1 <= 1'b0;
    end else begin
      rvld0 <= core_vld & (core_id == REQ0);
      rvld1 <= core_vld & (core_id == REQ1);
      if (core_vld) begin
        res <= core_prod;
      end
    end
  end

  // A product leaves the count on the edge that raises its rvld.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      inflight <= 2'd0;
    end else begin
      case ({xfer, core_vld})
        2'b10:   inflight <= inflight + 2'd1;
        2'b01:   inflight <= inflight - 2'd1;
        default: inflight <= inflight;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter: directed vector table, clear sequence,
// and randomized traffic against a queue-based reference model.
module tb_mul_share_arbiter;
  import mul_arb_pkg::*;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           clr;
  logic           req0, req1;
  logic [W-1:0]   a0, b0, a1, b1;
  logic           gnt0, gnt1, rvld0, rvld1;
  logic [2*W-1:0] res;
  logic [1:0]     inflight;

  always #5 clk = ~clk;

  mul_share_arbiter #(.W(W)) dut (
    .clk      (clk),
    .clr      (clr),
    .req0     (req0),
    .a0       (a0),
    .b0       (b0),
    .gnt0     (gnt0),
    .req1     (req1),
    .a1       (a1),
    .b1       (b1),
    .gnt1     (gnt1),
    .res      (res),
    .rvld0    (rvld0),
    .rvld1    (rvld1),
    .inflight (inflight)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: products waiting to come back, in issue order.
  typedef struct {
    int id;
    int prod;
    int issued;
  } item_t;

  item_t m_q[$];
  int    m_ptr;
  int    m_res;
  int    m_v0, m_v1;
  int    cyc = 0;

  typedef struct {
    bit r0; int x0; int y0;
    bit r1; int x1; int y1;
    bit g0; bit g1; bit v0; bit v1;
    int rs; int inf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r0, int x0, int y0, bit r1, int x1, int y1,
                              bit g0, bit g1, bit v0, bit v1, int rs, int inf);
    vec_t v;
    v.r0 = r0; v.x0 = x0; v.y0 = y0;
    v.r1 = r1; v.x1 = x1; v.y1 = y1;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1;
    v.rs = rs; v.inf = inf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ptr = 0;
    m_res = 0;
    m_v0  = 0;
    m_v1  = 0;
  endtask

  // One clock cycle: called just after a rising edge, returns just after the next one.
  task automatic step(input bit r0, input int x0, input int y0,
                      input bit r1, input int x1, input int y1,
                      output logic g0o, output logic g1o, output logic v0o, output logic v1o,
                      output logic [31:0] rso, output logic [31:0] info);
    int  win;
    item_t it;
    req0 = r0; a0 = W'(x0); b0 = W'(y0);
    req1 = r1; a1 = W'(x1); b1 = W'(y1);
    @(negedge clk);
    win = -1;
    if (r0 && r1) begin
`ifdef MUL_ARB_FIXED_PRIO_EN
      win = 0;
`else
      win = m_ptr;
`endif
    end else if (r0) begin
      win = 0;
    end else if (r1) begin
      win = 1;
    end
    g0o = gnt0;
    g1o = gnt1;
    chk("gnt0", 32'(gnt0), 32'(win == 0));
    chk("gnt1", 32'(gnt1), 32'(win == 1));
    @(posedge clk);
    cyc++;
    if (win >= 0) begin
      it.id     = win;
      it.prod   = (win == 0) ? (x0 % 16) * (y0 % 16) : (x1 % 16) * (y1 % 16);
      it.issued = cyc;
      m_q.push_back(it);
      m_ptr = 1 - win;
    end
    m_v0 = 0;
    m_v1 = 0;
    if (m_q.size() > 0 && m_q[0].issued == cyc - LAT) begin
      it = m_q.pop_front();
      m_res = it.prod;
      if (it.id == 0) m_v0 = 1; else m_v1 = 1;
    end
    #1;
    v0o  = rvld0;
    v1o  = rvld1;
    rso  = 32'(res);
    info = 32'(inflight);
    chk("rvld0", 32'(rvld0), 32'(m_v0));
    chk("rvld1", 32'(rvld1), 32'(m_v1));
    chk("res", 32'(res), 32'(m_res));
    chk("inflight", 32'(inflight), 32'(m_q.size()));
  endtask

  // Assert clr mid-cycle with requests pending; everything must read zero.
  task automatic do_clr();
    #2;
    clr  = 1'b1;
    req0 = 1'b1;
    req1 = 1'b1;
    #1;
    chk("clr_gnt0", 32'(gnt0), 32'd0);
    chk("clr_gnt1", 32'(gnt1), 32'd0);
    chk("clr_rvld", 32'({rvld0, rvld1}), 32'd0);
    chk("clr_res", 32'(res), 32'd0);
    chk("clr_inflight", 32'(inflight), 32'd0);
    @(posedge clk);
    #1;
    clr  = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    model_reset();
  endtask

  logic        g0, g1, v0, v1;
  logic [31:0] rs, inf;
  int          hc;

  initial begin
    clr = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_clr();

    for (int i = 0; i < 5; i++) tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0,0, 0,0));

`ifdef MUL_ARB_FIXED_PRIO_EN
    tbl.push_back(mk(1,3,4, 1,7,2, 1,0,0,0,  0,1));
    tbl.push_back(mk(1,3,4, 1,7,2, 1,0,0,0,  0,2));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1,3,4, 1,7,2, 1,0,1,0, 12,2));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,1,0, 12,1));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,1,0, 12,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0,0, 12,0));
    hc = 12;
`else
    tbl.push_back(mk(1,3,4, 1,7,2, 1,0,0,0,  0,1));
    tbl.push_back(mk(1,3,4, 1,7,2, 0,1,0,0,  0,2));
    tbl.push_back(mk(1,3,4, 1,7,2, 1,0,1,0, 12,2));
    tbl.push_back(mk(1,3,4, 1,7,2, 0,1,0,1, 14,2));
    tbl.push_back(mk(1,3,4, 1,7,2, 1,0,1,0, 12,2));
    tbl.push_back(mk(1,3,4, 1,7,2, 0,1,0,1, 14,2));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,1,0, 12,1));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0,1, 14,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0,0, 14,0));
    hc = 14;
`endif
    tbl.push_back(mk(1,5,5, 0,0,0, 1,0,0,0, hc,1));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0,0, hc,1));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,1,0, 25,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0,0, 25,0));
    tbl.push_back(mk(1,15,15, 0,0,0, 1,0,0,0, 25,1));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0,0, 25,1));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,1,0, 225,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0,0, 225,0));
    tbl.push_back(mk(0,0,0, 1,9,9, 0,1,0,0, 225,1));
    tbl.push_back(mk(0,0,0, 1,2,3, 0,1,0,0, 225,2));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0,1, 81,1));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0,1, 6,0));

    foreach (tbl[i]) begin
      step(tbl[i].r0, tbl[i].x0, tbl[i].y0, tbl[i].r1, tbl[i].x1, tbl[i].y1,
           g0, g1, v0, v1, rs, inf);
      chk($sformatf("tbl%0d_gnt0", i), 32'(g0), 32'(tbl[i].g0));
      chk($sformatf("tbl%0d_gnt1", i), 32'(g1), 32'(tbl[i].g1));
      chk($sformatf("tbl%0d_rvld0", i), 32'(v0), 32'(tbl[i].v0));
      chk($sformatf("tbl%0d_rvld1", i), 32'(v1), 32'(tbl[i].v1));
      chk($sformatf("tbl%0d_res", i), rs, 32'(tbl[i].rs));
      chk($sformatf("tbl%0d_inflight", i), inf, 32'(tbl[i].inf));
    end

    // Two products in flight, then clear before either returns.
    step(1, 5, 5, 0, 0, 0, g0, g1, v0, v1, rs, inf);
    step(0, 0, 0, 1, 6, 6, g0, g1, v0, v1, rs, inf);
    do_clr();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0, g0, g1, v0, v1, rs, inf);
      chk("postclr_rvld", 32'({v0, v1}), 32'd0);
      chk("postclr_inflight", inf, 32'd0);
    end
    // First edge after release accepts normally.
    step(1, 2, 3, 0, 0, 0, g0, g1, v0, v1, rs, inf);
    chk("postclr_first_gnt", 32'(g0), 32'd1);
    step(0, 0, 0, 0, 0, 0, g0, g1, v0, v1, rs, inf);
    step(0, 0, 0, 0, 0, 0, g0, g1, v0, v1, rs, inf);
    chk("postclr_first_res", rs, 32'd6);
    chk("postclr_first_rvld0", 32'(v0), 32'd1);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_clr();
      end else begin
        step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             g0, g1, v0, v1, rs, inf);
      end
    end

    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, g0, g1, v0, v1, rs, inf);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
